mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers. It is the next generation of the single-cycle HI/LO multiply path in the MIPS datapath.
- It adds signed and unsigned divide, MTHI/MTLO writes, a start/busy/done handshake and an abort.
- It sits beside the ALU. The datapath issues an op, stalls on busy, then reads hi/lo through its MFHI/MFLO mux.
- It computes one quotient or product bit per cycle, so the datapath stays single-width.

Parameters:
- WIDTH, 32, operand and HI/LO register width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  op request, sampled on a rising clk edge while idle.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 11x reserved.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- abort  in  1  cancels the operation in flight.
- busy  out  1  high while an op is in progress; the datapath stalls on busy.
- done  out  1  one-cycle pulse; hi/lo hold the final result during that cycle.
- div_by_zero  out  1  sticky; set by a DIV/DIVU with b==0, cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter and working registers cleared. This overrides any op in flight.
- States: IDLE, PREP, RUN, FIX.
  - IDLE: start with op 000-011 → PREP; a and b are latched at that edge; busy rises after the edge.
  - PREP (1 cycle): signed ops take magnitudes of a and b and record the result signs; counter=WIDTH.
  - PREP with b==0 on DIV/DIVU → FIX directly.
  - RUN (WIDTH cycles): one iteration per cycle; counter decrements; at counter==1 → FIX.
  - FIX (1 cycle): applies sign correction, writes hi/lo, pulses done, lowers busy, → IDLE.
- Latency: start sampled at edge N → hi/lo written and done high after edge N+WIDTH+2 (div-by-zero: N+2). busy is high for exactly WIDTH+2 cycles on a normal op.
- MULT/MULTU: radix-2 shift-add over a 2*WIDTH accumulator.
  - {hi,lo} is the full 2*WIDTH-bit product.
  - MULT negates the product when the operand signs differ.
- DIV/DIVU: restoring shift-subtract. lo=quotient, hi=remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1), hi=0. No trap.
  - Divide by zero: hi=a, lo=all ones, div_by_zero=1.
- MTHI/MTLO: hi (or lo) = a at the start edge. Takes no busy cycles; done pulses in the next cycle; the other register is unchanged.
- Reserved op: start is ignored, no done.
- start while busy: ignored. The datapath must hold it until busy drops.
- abort while busy: → IDLE at the next edge; busy=0; no done; hi/lo and div_by_zero keep their pre-op values.
- abort while idle: no effect.
- abort and start in the same idle cycle: abort wins; the start is dropped.
- hi/lo change only in FIX, on an MTHI/MTLO start edge, or on reset. Intermediate values are never visible on hi/lo.
- The accumulator and remainder are WIDTH+1 bits internally. There is no overflow or wrap beyond the defined results above.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFD(-3), b=5 → done at start+34; hi=FFFFFFFF, lo=FFFFFFF1; busy high for 34 cycles.
- MULTU a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. MULT on the same operands → hi=0, lo=1.
- DIV a=FFFFFFF9(-7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIVU a=7, b=0 → done at start+2; hi=7, lo=FFFFFFFF, div_by_zero=1. A following MTLO a=5 clears the flag; lo=5, hi stays 7.
- Start MULT, assert abort at cycle 10 → no done, busy=0 next cycle, hi/lo unchanged. A start pulse mid-op is ignored: exactly one done.
- Drive rst low at cycle 15 of a DIV → hi=lo=0 and busy=0 immediately, asynchronously. After release, a fresh MULTU 3*4 → lo=C, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit with HI/LO result registers for the MIPS
// datapath. It produces one product or quotient bit per clock, so the
// datapath stays single width. The datapath issues an op with start, stalls
// while busy is high, and reads hi/lo through its MFHI/MFLO mux.
//
// Operations (op):
//   000 MULTU  {hi,lo} = a * b            (unsigned)
//   001 MULT   {hi,lo} = a * b            (signed)
//   010 DIVU   lo = a / b, hi = a % b     (unsigned)
//   011 DIV    lo = a / b, hi = a % b     (signed, truncates toward zero)
//   100 MTHI   hi = a                     (no busy cycles)
//   101 MTLO   lo = a                     (no busy cycles)
//   11x        reserved; start is ignored
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        op request, sampled on a rising edge while idle
//   op[2:0]      operation select (table above)
//   a[WIDTH]     rs operand: multiplicand, dividend or MTHI/MTLO data
//   b[WIDTH]     rt operand: multiplier or divisor
//   abort        cancels the op in flight; hi/lo/div_by_zero keep old values
//   busy         high while a multiply/divide is in progress
//   done         one-cycle pulse; hi/lo already hold the final result
//   div_by_zero  sticky; set by DIV/DIVU with b==0, cleared by the next
//                accepted start
//   hi, lo       HI and LO registers
//
// Timing: start sampled at edge N -> done high after edge N+WIDTH+2
// (divide by zero: N+2; MTHI/MTLO: N). busy is high WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Iteration counter must hold the value WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operands. In PREP, b_r is replaced by |b|; a_r keeps the raw
    // dividend because a divide by zero returns it unchanged in hi.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             is_div_r;
    logic             is_signed_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             dbz_prev_r;   // div_by_zero before the op, restored on abort

    // Working registers: acc_r is the upper partial product / partial
    // remainder, q_r shifts the multiplier out and the product/quotient in.
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;

    logic accept_md;
    logic accept_mt;
    logic b_zero;
    logic abort_busy;

    assign accept_md  = (state == IDLE) && start && !abort && (op[2] == 1'b0);
    assign accept_mt  = (state == IDLE) && start && !abort && (op[2:1] == 2'b10);
    assign b_zero     = (b_r == '0);
    assign abort_busy = (state != IDLE) && abort;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values, independent of block ordering.
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept_md) state_next = PREP;
            end
            PREP: begin
                if (abort)                    state_next = IDLE;
                else if (is_div_r && b_zero)  state_next = FIX;
                else                          state_next = RUN;
            end
            RUN: begin
                if (abort)                        state_next = IDLE;
                else if (cnt_r == CNT_W'(1))      state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state != IDLE);
    end

    // -------------------------------------------------------------------------
    // Operand magnitudes (signed ops only). |-2^(WIDTH-1)| = 2^(WIDTH-1) still
    // fits as an unsigned WIDTH-bit value, so the overflow case needs no
    // special handling.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        mag_a = (is_signed_r && a_r[WIDTH-1]) ? -a_r : a_r;
        mag_b = (is_signed_r && b_r[WIDTH-1]) ? -b_r : b_r;
    end

    // -------------------------------------------------------------------------
    // One iteration step.
    //   multiply: acc += q[0] ? |b| : 0, then shift {acc,q} right by one.
    //   divide:   shift {acc,q} left by one, subtract |b| if it fits
    //             (restoring), shift the outcome bit into q.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        mul_sum   = acc_r + (q_r[0] ? {1'b0, b_r} : '0);
        div_shift = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_r};
        if (is_div_r) begin
            if (!div_diff[WIDTH+1]) begin
                acc_step = div_diff[WIDTH:0];
                q_step   = {q_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift;
                q_step   = {q_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {1'b0, mul_sum[WIDTH:1]};
            q_step   = {mul_sum[0], q_r[WIDTH-1:1]};
        end
    end

    // -------------------------------------------------------------------------
    // Sign correction applied in FIX.
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod     = {acc_r[WIDTH-1:0], q_r};
        prod_fix = (sign_a_r ^ sign_b_r) ? -prod : prod;
        quo_fix  = (sign_a_r ^ sign_b_r) ? -q_r : q_r;
        // Remainder follows the sign of the dividend.
        rem_fix  = sign_a_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    end

    // -------------------------------------------------------------------------
    // Datapath and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: working registers are reset as well as the visible ones;
            // they are plain flops, not a memory array, so this is cheap and
            // keeps every register defined right after reset.
            a_r         <= '0;
            b_r         <= '0;
            is_div_r    <= 1'b0;
            is_signed_r <= 1'b0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            dbz_prev_r  <= 1'b0;
            acc_r       <= '0;
            q_r         <= '0;
            cnt_r       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;

            if (accept_md) begin
                a_r         <= a;
                b_r         <= b;
                is_div_r    <= op[1];
                is_signed_r <= op[0];
                dbz_prev_r  <= div_by_zero;
                div_by_zero <= 1'b0;
            end

            if (accept_mt) begin
                if (op[0]) lo <= a;
                else       hi <= a;
                div_by_zero <= 1'b0;
                done        <= 1'b1;
            end

            // An abort undoes the flag clear done when the op was accepted.
            if (abort_busy) begin
                div_by_zero <= dbz_prev_r;
            end

            unique case (state)
                PREP: begin
                    sign_a_r <= is_signed_r & a_r[WIDTH-1];
                    sign_b_r <= is_signed_r & b_r[WIDTH-1];
                    b_r      <= mag_b;
                    q_r      <= mag_a;
                    acc_r    <= '0;
                    cnt_r    <= CNT_W'(WIDTH);
                end
                RUN: begin
                    acc_r <= acc_step;
                    q_r   <= q_step;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                FIX: begin
                    if (!abort) begin
                        if (is_div_r && b_zero) begin
                            hi          <= a_r;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (is_div_r) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit (WIDTH=32). Expected hi/lo and flags
// come from a reference model using plain 64-bit integer arithmetic; latency
// and busy length are checked against the documented cycle counts.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state.
    logic [WIDTH-1:0] hi_m;
    logic [WIDTH-1:0] lo_m;
    logic             dbz_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: effect of a completed op on hi/lo/div_by_zero.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; {hi_m, lo_m} = p; dbz_m = 1'b0; end
            3'd1: begin sp = sx * sy; {hi_m, lo_m} = sp; dbz_m = 1'b0; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    hi_m = x; lo_m = '1; dbz_m = 1'b1;
                end else if (o == 3'd2) begin
                    lo_m = x / y; hi_m = x % y; dbz_m = 1'b0;
                end else begin
                    sq = sx / sy; sr = sx % sy;
                    lo_m = 32'(sq); hi_m = 32'(sr); dbz_m = 1'b0;
                end
            end
            3'd4: begin hi_m = x; dbz_m = 1'b0; end
            3'd5: begin lo_m = x; dbz_m = 1'b0; end
            default: ;
        endcase
    endtask

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] y);
        if (o[2]) return 0;
        if (o[1] && y == 0) return 2;
        return WIDTH + 2;
    endfunction

    // Issue one op, wait for done, compare against the model.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          lat;
        int          nb;
        int          want;
        bit          leak;
        bit          saw;
        pre_hi = hi_m;
        pre_lo = lo_m;
        lat    = -1;
        nb     = 0;
        leak   = 1'b0;
        saw    = 1'b0;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        if (o[2:1] == 2'b11) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (done || busy) saw = 1'b1;
                @(negedge clk);
            end
            check($sformatf("rsv%0d_ignored", o), saw, 1'b0);
            check($sformatf("rsv%0d_hi", o), hi, hi_m);
            check($sformatf("rsv%0d_lo", o), lo, lo_m);
            return;
        end
        want = exp_latency(o, y);
        for (int i = 1; i <= WIDTH + 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Operands must have been latched; scramble the inputs.
                start = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            if (busy) nb++;
            if (done) begin
                lat = i - 1;
                break;
            end
            if (hi !== pre_hi || lo !== pre_lo) leak = 1'b1;
        end
        model_apply(o, x, y);
        check($sformatf("op%0d latency", o), lat, want);
        check($sformatf("op%0d busy_cycles", o), nb, want);
        check($sformatf("op%0d hi %h,%h", o, x, y), hi, hi_m);
        check($sformatf("op%0d lo %h,%h", o, x, y), lo, lo_m);
        check($sformatf("op%0d div_by_zero", o), div_by_zero, dbz_m);
        check($sformatf("op%0d no_intermediate", o), leak, 1'b0);
        @(negedge clk);
        check($sformatf("op%0d done_one_cycle", o), done, 1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = $urandom_range(0, 15);
            5: begin v = $urandom_range(1, 15); v = -v; end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Global bound so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  ndone;
        bit  saw;
        rst = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
        hi_m = '0; lo_m = '0; dbz_m = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset dbz", div_by_zero, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        rst = 1'b1;

        // Directed cases
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
        check("tp mult hi", hi, 32'hFFFF_FFFF);
        check("tp mult lo", lo, 32'hFFFF_FFF1);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("tp multu hi", hi, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        check("tp div lo", lo, 32'hFFFF_FFFD);
        run_op(3'd2, 32'd7, 32'd2);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("tp div ovf lo", lo, 32'h8000_0000);
        run_op(3'd2, 32'd7, 32'd0);
        check("tp dbz flag", div_by_zero, 1'b1);

        // Abort mid-MULT: no done, busy drops, hi/lo/div_by_zero unchanged
        @(negedge clk);
        op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < WIDTH + 5; i++) begin
            if (done) saw = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", saw, 1'b0);
        check("abort hi", hi, hi_m);
        check("abort lo", lo, lo_m);
        check("abort dbz", div_by_zero, dbz_m);

        // MTLO clears the flag, hi stays
        run_op(3'd5, 32'd5, 32'd0);
        check("tp mtlo hi kept", hi, 32'd7);

        // Abort and start together while idle: start dropped
        @(negedge clk);
        op = 3'd4; a = 32'hCAFE_F00D; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort+start done", done, 1'b0);
        check("abort+start busy", busy, 1'b0);
        check("abort+start hi", hi, hi_m);

        // Start pulse mid-op is ignored: exactly one done
        @(negedge clk);
        op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= WIDTH + 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 5) begin op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1; end
            if (i == 6) start = 1'b0;
            if (done) ndone++;
        end
        model_apply(3'd0, 32'd6, 32'd7);
        check("midstart done_count", ndone, 1);
        check("midstart hi", hi, hi_m);
        check("midstart lo", lo, lo_m);

        // Asynchronous reset during a DIV
        @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        hi_m = '0; lo_m = '0; dbz_m = 1'b0;
        check("async rst hi", hi, 32'h0);
        check("async rst lo", lo, 32'h0);
        check("async rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_op(3'd0, 32'd3, 32'd4);
        check("tp post-reset lo", lo, 32'hC);

        // Randomized ops against the model
        for (int k = 0; k < 48; k++) begin
            run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
